fft_seq_p: RTL



---
 rtl/fft_pkg.sv | 46 ++++
 rtl/fft_addr_map.sv | 25 ++
 rtl/fft_seq_p.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared types, encodings and size helpers for the FFT sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

    localparam logic [1:0] c_route_pass  = 2'd0;
    localparam logic [1:0] c_route_pair  = 2'd1;
    localparam logic [1:0] c_route_cross = 2'd2;

    // Widest bank address supported (LOG2N = 12).
    localparam int c_max_aw = 10;

    function automatic int calc_aw(input int log2n);
        return log2n - 2;
    endfunction

    function automatic int calc_depth(input int log2n);
        return 1 << calc_aw(log2n);
    endfunction

    function automatic int calc_nstg(input int log2n);
        return log2n - 1;
    endfunction

    // Inverts the top s bits of an aw-bit count; s >= aw inverts every bit.
    function automatic logic [c_max_aw-1:0] inv_top(input logic [c_max_aw-1:0] cnt,
                                                    input int s, input int aw);
        logic [c_max_aw-1:0] full;
        full = c_max_aw'((1 << aw) - 1);
        return cnt ^ (full & ~(full >> s));
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_addr_map.sv
// ============================================================================
//  Module   : fft_addr_map
//  Purpose  : Stage-dependent bank address pair for one side (read or write).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_addr_map #(
    parameter int AW = 6
) (
    input  logic [AW-1:0] i_cnt,
    input  logic [3:0]    i_stage,
    output logic [AW-1:0] o_addr0,
    output logic [AW-1:0] o_addr1
);
    import fft_pkg::*;

    always_comb begin
        o_addr0 = i_cnt;
        o_addr1 = AW'(inv_top(c_max_aw'(i_cnt), int'(i_stage), AW));
    end

endmodule

`default_nettype wire

// File: rtl/fft_seq_p.sv
// ============================================================================
//  Module   : fft_seq_p
//  Purpose  : Parametrised address/route sequencer for the in-place radix-2 FFT.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_seq_p #(
    parameter int LOG2N  = 8,
    parameter int PE_LAT = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Inverse,
    input  logic [LOG2N-2:0] Scale_mask,
    input  logic             Host_sel,
    input  logic [LOG2N-3:0] Host_addr,
    input  logic             Host_we,
    output logic             Busy,
    output logic             Done,
    output logic [LOG2N-3:0] Rd_addr0,
    output logic [LOG2N-3:0] Rd_addr1,
    output logic [LOG2N-3:0] Wr_addr0,
    output logic [LOG2N-3:0] Wr_addr1,
    output logic             We,
    output logic [LOG2N-1:0] Tf_addr,
    output logic             Tf_conj,
    output logic [1:0]       Rd_route,
    output logic             Wr_swap,
    output logic             Bypass_n,
    output logic             Scale_en,
    output logic [3:0]       Stage
);
    import fft_pkg::*;

    localparam int            AW       = calc_aw(LOG2N);
    localparam int            DEPTH    = calc_depth(LOG2N);
    localparam int            NSTG     = calc_nstg(LOG2N);
    localparam int            LAT      = PE_LAT + 1;
    localparam logic [AW-1:0] LAST_CNT = AW'(DEPTH - 1);
    localparam logic [3:0]    LAST_STG = 4'(NSTG - 1);

    fft_state_t      r_state, w_state_nxt;
    logic [AW-1:0]   r_rd_cnt;
    logic [3:0]      r_stage;
    logic            r_inv;
    logic [NSTG-1:0] r_mask;
    logic            r_wv [LAT];
    logic [AW-1:0]   r_wc [LAT];

    logic            w_wr_vld, w_accept, w_stage_end, w_busy;
    logic [AW-1:0]   w_wr_cnt;
    logic [AW-1:0]   w_rd_a0, w_rd_a1, w_wr_a0, w_wr_a1;
    logic [AW-1:0]   w_low_mask, w_low, w_top;
    logic [LOG2N-1:0] w_tf;
    logic [1:0]      w_route;
    logic            w_cross_bit, w_swap, w_scale;

    assign w_wr_vld    = r_wv[LAT-1];
    assign w_wr_cnt    = r_wc[LAT-1];
    assign w_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_accept    = (r_state == ST_IDLE) && Start;
    assign w_stage_end = (r_state == ST_DRAIN) && w_wr_vld && (w_wr_cnt == LAST_CNT);

    always_ff @(posedge Clk) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_state_nxt = ST_RUN;
            ST_RUN:   if (r_rd_cnt == LAST_CNT) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_stage_end) w_state_nxt = (r_stage == LAST_STG) ? ST_DONE : ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Write side is the read count delayed by the BRAM read plus PE latency.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rd_cnt <= '0;
            r_stage  <= '0;
            r_inv    <= 1'b0;
            r_mask   <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_wv[i] <= 1'b0;
                r_wc[i] <= '0;
            end
        end else begin
            if (r_state == ST_RUN) r_rd_cnt <= r_rd_cnt + AW'(1);
            r_wv[0] <= (r_state == ST_RUN);
            r_wc[0] <= r_rd_cnt;
            for (int i = 1; i < LAT; i++) begin
                r_wv[i] <= r_wv[i-1];
                r_wc[i] <= r_wc[i-1];
            end
            if (w_accept) begin
                r_stage <= '0;
                r_inv   <= Inverse;
                r_mask  <= Scale_mask;
            end else if (w_stage_end) begin
                r_stage <= (r_stage == LAST_STG) ? 4'd0 : r_stage + 4'd1;
            end
        end
    end

    fft_addr_map #(.AW(AW)) u_rd_map (
        .i_cnt   (r_rd_cnt),
        .i_stage (r_stage),
        .o_addr0 (w_rd_a0),
        .o_addr1 (w_rd_a1)
    );

    fft_addr_map #(.AW(AW)) u_wr_map (
        .i_cnt   (w_wr_cnt),
        .i_stage (r_stage),
        .o_addr0 (w_wr_a0),
        .o_addr1 (w_wr_a1)
    );

    always_comb begin
        w_low_mask  = {AW{1'b1}} >> r_stage;
        w_low       = r_rd_cnt & w_low_mask;
        w_top       = r_rd_cnt & ~w_low_mask;
        w_cross_bit = |(r_rd_cnt & (AW'(1) << (4'(AW) - r_stage)));
        w_swap      = (r_stage < LAST_STG) &&
                      (|(w_wr_cnt & (AW'(1) << (4'(AW - 1) - r_stage))));
        w_scale     = |(r_mask & (NSTG'(1) << r_stage));

        if (r_stage == 4'd0)          w_tf = LOG2N'(r_rd_cnt);
        else if (r_stage == LAST_STG) w_tf = '0;
        else if (w_top == '0)         w_tf = LOG2N'(w_low) << r_stage;
        else                          w_tf = LOG2N'(w_low) << (r_stage + 4'd1);

        w_route = c_route_pair;
        if (r_stage != 4'd0) begin
            if (w_top == '0)
                w_route = c_route_pass;
            else if ((r_stage <= 4'(AW)) && w_cross_bit)
                w_route = c_route_cross;
        end
    end

    always_comb begin
        Busy     = w_busy;
        Done     = (r_state == ST_DONE);
        Rd_addr0 = '0;
        Rd_addr1 = '0;
        Wr_addr0 = '0;
        Wr_addr1 = '0;
        We       = 1'b0;
        Tf_addr  = '0;
        Rd_route = c_route_pass;
        Wr_swap  = 1'b0;
        Scale_en = 1'b0;
        Tf_conj  = r_inv;
        Bypass_n = (r_stage != LAST_STG);
        Stage    = r_stage;
        if (w_busy) begin
            Rd_addr0 = w_rd_a0;
            Rd_addr1 = w_rd_a1;
            Tf_addr  = w_tf;
            Rd_route = w_route;
            if (w_wr_vld) begin
                Wr_addr0 = w_wr_a0;
                Wr_addr1 = w_wr_a1;
                We       = 1'b1;
                Wr_swap  = w_swap;
                Scale_en = w_scale;
            end
        end else if (Host_sel) begin
            Rd_addr0 = Host_addr;
            Rd_addr1 = Host_addr;
            Wr_addr0 = Host_addr;
            Wr_addr1 = Host_addr;
            We       = Host_we;
            Tf_addr  = {2'b00, Host_addr};
        end
    end

endmodule

`default_nettype wire
